// File: rtl/npc_lsu_if.sv
// Handshake bundle between the NPC core (EXU request, WBU response), the LSU and data memory.
// The master side is the core/memory environment, the slave side is the LSU.
interface npc_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wmask;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_wen;
    logic [1:0]        rsp_err;

    modport master (
        output req_valid, req_wen, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata,
        input  rsp_valid, rsp_data, rsp_rd, rsp_wen, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_wen, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata,
        output rsp_valid, rsp_data, rsp_rd, rsp_wen, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/npc_lsu.sv
// Multi-cycle load/store unit: one op at a time, aligned byte-masked memory port, extended load result.
// Define LSU_TIMEOUT_EN to add a memory response watchdog that reports err=2 after TIMEOUT_CYCLES.
module npc_lsu #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic     clk,
    input  logic     rst,
    npc_lsu_if.slave bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state;
    logic             wen_q;
    logic [2:0]       funct3_q;
    logic [OFF_W-1:0] off_q;
    logic [4:0]       rd_q;

    logic [OFF_W-1:0] req_off;
    logic [XLEN-1:0]  rdata_shifted;
    logic [XLEN-1:0]  load_data;
    logic             mem_done;
    logic             tmo_hit;

    function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            default: return (XLEN == 32) || (a != 3'b000);
        endcase
    endfunction

    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return NB'(1);
            2'd1:    return NB'(3);
            2'd2:    return NB'(15);
            default: return '1;
        endcase
    endfunction

    // Keep the low 'size' bytes, then fill the rest with the top kept bit or zeros.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw, input logic [2:0] f3);
        logic [XLEN-1:0] keep;
        logic            sgn;
        case (f3[1:0])
            2'd0:    begin keep = XLEN'(8'hFF);         sgn = raw[7];  end
            2'd1:    begin keep = XLEN'(16'hFFFF);      sgn = raw[15]; end
            2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sgn = raw[31]; end
            default: begin keep = '1;                   sgn = 1'b0;    end
        endcase
        return (raw & keep) | ((sgn && !f3[2]) ? ~keep : '0);
    endfunction

    assign req_off = bus.req_addr[OFF_W-1:0];

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        rdata_shifted = bus.mem_rdata >> {off_q, 3'b000};
        load_data     = extend_load(rdata_shifted, funct3_q);
    end

    // A response in REQ counts only together with the request handshake.
    assign mem_done = ((state == REQ && bus.mem_ready) || state == WAIT) && bus.mem_rvalid;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;

    // REQ is only entered from IDLE, so clearing in IDLE clears it on entry to REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (state == REQ || state == WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == REQ || state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wen_q         <= 1'b0;
            funct3_q      <= 3'd0;
            off_q         <= '0;
            rd_q          <= 5'd0;
            bus.req_ready <= 1'b1;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wen   <= 1'b0;
            bus.mem_wdata <= '0;
            bus.mem_wmask <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_rd    <= 5'd0;
            bus.rsp_wen   <= 1'b0;
            bus.rsp_err   <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wen_q         <= bus.req_wen;
                        funct3_q      <= bus.req_funct3;
                        off_q         <= req_off;
                        rd_q          <= bus.req_rd;
                        bus.req_ready <= 1'b0;
                        if (misaligned(bus.req_addr[2:0], bus.req_funct3[1:0])) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= '0;
                            bus.rsp_rd    <= bus.req_rd;
                            bus.rsp_wen   <= 1'b0;
                            bus.rsp_err   <= ERR_MISALIGN;
                        end else begin
                            state         <= REQ;
                            bus.mem_valid <= 1'b1;
                            bus.mem_addr  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            bus.mem_wen   <= bus.req_wen;
                            bus.mem_wdata <= bus.req_wdata << {req_off, 3'b000};
                            bus.mem_wmask <= bus.req_wen ? size_mask(bus.req_funct3[1:0]) << req_off : '0;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (mem_done) begin
                        state         <= RESP;
                        bus.mem_valid <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= wen_q ? '0 : load_data;
                        bus.rsp_rd    <= rd_q;
                        bus.rsp_wen   <= !wen_q;
                        bus.rsp_err   <= ERR_OK;
                    end else if (tmo_hit) begin
                        state         <= RESP;
                        bus.mem_valid <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= '0;
                        bus.rsp_rd    <= rd_q;
                        bus.rsp_wen   <= 1'b0;
                        bus.rsp_err   <= ERR_TIMEOUT;
                    end else if (state == REQ && bus.mem_ready) begin
                        state         <= WAIT;
                        bus.mem_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npc_lsu.sv
// Scoreboard bench for npc_lsu (XLEN=32): directed ops, memory/response models with per-op stalls.
// Build with LSU_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_npc_lsu;
`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        int          stall;
        bit          fast;
        bit          respond;
    } mem_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  err;
        int          lat;
        int          stall;
        int          t0;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rsp_done = 0;
    int   exp_done = 0;
    int   mem_wait = 0;
    int   rsp_wait = 0;
    bit   resp_due = 1'b0;
    logic [31:0] resp_data = '0;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];

    npc_lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

    npc_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic mem_exp_t mk_mem(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                                        input logic [3:0] wmask, input logic [31:0] rdata, input int stall,
                                        input bit fast, input bit respond);
        mem_exp_t m;
        m.addr = addr; m.wen = wen; m.wdata = wdata; m.wmask = wmask;
        m.rdata = rdata; m.stall = stall; m.fast = fast; m.respond = respond;
        return m;
    endfunction

    function automatic rsp_exp_t mk_rsp(input logic [31:0] data, input logic [4:0] rd, input logic wen,
                                        input logic [1:0] err, input int lat, input int stall);
        rsp_exp_t r;
        r.data = data; r.rd = rd; r.wen = wen; r.err = err; r.lat = lat; r.stall = stall; r.t0 = 0;
        return r;
    endfunction

    // Memory model: honours per-op stall, answers one cycle after the handshake (or with it when fast).
    initial begin
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (rst) begin
                mem_wait = 0;
                resp_due = 1'b0;
            end else begin
                if (resp_due) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = resp_data;
                    resp_due       = 1'b0;
                end
                if (bus.mem_valid) begin
                    if (mem_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_unexpected: got mem_valid=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        check("mem_addr", bus.mem_addr, mem_q[0].addr);
                        check("mem_wen", bus.mem_wen, mem_q[0].wen);
                        check("mem_wmask", bus.mem_wmask, mem_q[0].wmask);
                        if (mem_q[0].wen) check("mem_wdata", bus.mem_wdata, mem_q[0].wdata);
                        check("req_ready_busy", bus.req_ready, 1'b0);
                        if (mem_wait < mem_q[0].stall) begin
                            mem_wait++;
                        end else begin
                            bus.mem_ready = 1'b1;
                            mem_wait      = 0;
                            if (mem_q[0].respond) begin
                                if (mem_q[0].fast) begin
                                    bus.mem_rvalid = 1'b1;
                                    bus.mem_rdata  = mem_q[0].rdata;
                                end else begin
                                    resp_due  = 1'b1;
                                    resp_data = mem_q[0].rdata;
                                end
                            end
                            void'(mem_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Response monitor: compares every cycle rsp_valid is up, releases rsp_ready after the op's stall.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            if (rst) begin
                rsp_wait = 0;
            end else if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    if (rsp_wait == 0 && rsp_q[0].lat >= 0)
                        check("rsp_latency", 64'(cyc - rsp_q[0].t0), 64'(rsp_q[0].lat));
                    check("rsp_data", bus.rsp_data, rsp_q[0].data);
                    check("rsp_rd", bus.rsp_rd, rsp_q[0].rd);
                    check("rsp_wen", bus.rsp_wen, rsp_q[0].wen);
                    check("rsp_err", bus.rsp_err, rsp_q[0].err);
                    check("req_ready_resp", bus.req_ready, 1'b0);
                    if (rsp_wait < rsp_q[0].stall) begin
                        rsp_wait++;
                    end else begin
                        bus.rsp_ready = 1'b1;
                        rsp_wait      = 0;
                        rsp_done++;
                        void'(rsp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input bit has_mem,
                         input mem_exp_t m, input rsp_exp_t r);
        int n;
        @(negedge clk);
        bus.req_wen    = wen;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        bus.req_valid  = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL req_accept: got req_ready=%b expected 1 within 100 cycles", bus.req_ready);
        end else begin
            r.t0 = cyc;
            if (has_mem) mem_q.push_back(m);
            rsp_q.push_back(r);
            exp_done++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rsp_q.size() != 0 || bus.req_ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL idle_timeout: got %0d pending responses expected 0", rsp_q.size());
            rsp_q.delete();
            mem_q.delete();
        end
    endtask

    task automatic run(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input bit has_mem,
                       input mem_exp_t m, input rsp_exp_t r);
        issue(wen, f3, addr, wdata, rd, has_mem, m, r);
        wait_idle();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 1'b1);
        check({tag, "_mem_valid"}, bus.mem_valid, 1'b0);
        check({tag, "_mem_wmask"}, bus.mem_wmask, 4'h0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_rsp_data"}, bus.rsp_data, 32'h0);
        check({tag, "_rsp_rd"}, bus.rsp_rd, 5'd0);
        check({tag, "_rsp_wen"}, bus.rsp_wen, 1'b0);
        check({tag, "_rsp_err"}, bus.rsp_err, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
        $fatal(1, "global timeout");
    end

    initial begin
        mem_exp_t none;
        none = mk_mem('0, 1'b0, '0, 4'h0, '0, 0, 1'b0, 1'b0);
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_rd     = 5'd0;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // lw, zero-wait memory: three cycles to rsp_valid
        run(1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd5, 1'b1,
            mk_mem(32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b1),
            mk_rsp(32'hDEAD_BEEF, 5'd5, 1'b1, 2'd0, 3, 0));
        // lb / lbu of byte 3 (0x80)
        run(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd6, 1'b1,
            mk_mem(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h8011_2233, 0, 1'b0, 1'b1),
            mk_rsp(32'hFFFF_FF80, 5'd6, 1'b1, 2'd0, 3, 0));
        run(1'b0, 3'b100, 32'h8000_0003, 32'h0, 5'd7, 1'b1,
            mk_mem(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h8011_2233, 0, 1'b0, 1'b1),
            mk_rsp(32'h0000_0080, 5'd7, 1'b1, 2'd0, 3, 0));
        // lh / lhu of upper half
        run(1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd8, 1'b1,
            mk_mem(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h8001_ABCD, 0, 1'b0, 1'b1),
            mk_rsp(32'hFFFF_8001, 5'd8, 1'b1, 2'd0, 3, 0));
        run(1'b0, 3'b101, 32'h8000_0002, 32'h0, 5'd9, 1'b1,
            mk_mem(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h8001_ABCD, 0, 1'b0, 1'b1),
            mk_rsp(32'h0000_8001, 5'd9, 1'b1, 2'd0, 3, 0));
        // sb / sh / sw lanes and strobes
        run(1'b1, 3'b000, 32'h8000_0002, 32'h0000_00AB, 5'd10, 1'b1,
            mk_mem(32'h8000_0000, 1'b1, 32'h00AB_0000, 4'h4, 32'h0, 0, 1'b0, 1'b1),
            mk_rsp(32'h0, 5'd10, 1'b0, 2'd0, 3, 0));
        run(1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 5'd11, 1'b1,
            mk_mem(32'h8000_0000, 1'b1, 32'h1234_0000, 4'hC, 32'h0, 0, 1'b0, 1'b1),
            mk_rsp(32'h0, 5'd11, 1'b0, 2'd0, 3, 0));
        run(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 5'd12, 1'b1,
            mk_mem(32'h8000_0008, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 1'b0, 1'b1),
            mk_rsp(32'h0, 5'd12, 1'b0, 2'd0, 3, 0));
        // misaligned lw / sh, and ld on a 32-bit LSU: error on the next cycle, no memory access
        run(1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd13, 1'b0, none,
            mk_rsp(32'h0, 5'd13, 1'b0, 2'd1, 1, 0));
        run(1'b1, 3'b001, 32'h8000_0001, 32'h5555, 5'd14, 1'b0, none,
            mk_rsp(32'h0, 5'd14, 1'b0, 2'd1, 1, 0));
        run(1'b0, 3'b011, 32'h8000_0000, 32'h0, 5'd15, 1'b0, none,
            mk_rsp(32'h0, 5'd15, 1'b0, 2'd1, 1, 0));
        // response together with the request handshake
        run(1'b0, 3'b010, 32'h8000_0000, 32'h0, 5'd16, 1'b1,
            mk_mem(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h7FFF_0001, 0, 1'b1, 1'b1),
            mk_rsp(32'h7FFF_0001, 5'd16, 1'b1, 2'd0, 2, 0));
        // back-pressure on both sides; monitors re-check stability every stalled cycle
        run(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd17, 1'b1,
            mk_mem(32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h0123_4567, 5, 1'b0, 1'b1),
            mk_rsp(32'h0123_4567, 5'd17, 1'b1, 2'd0, -1, 3));
        // rd=0 load still requests a write
        run(1'b0, 3'b100, 32'h8000_0001, 32'h0, 5'd0, 1'b1,
            mk_mem(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_FF00, 0, 1'b0, 1'b1),
            mk_rsp(32'h0000_00FF, 5'd0, 1'b1, 2'd0, 3, 0));

`ifdef LSU_TIMEOUT_EN
        // memory never answers: 16 cycles in REQ/WAIT, then err=2
        run(1'b0, 3'b010, 32'h8000_0040, 32'h0, 5'd18, 1'b1,
            mk_mem(32'h8000_0040, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0, 1'b0),
            mk_rsp(32'h0, 5'd18, 1'b0, 2'd2, 17, 0));
`endif

        // reset while waiting for a response that never comes
        issue(1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd19, 1'b1,
              mk_mem(32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0, 1'b0),
              mk_rsp(32'h0, 5'd19, 1'b1, 2'd0, -1, 0));
        repeat (4) @(negedge clk);
        check("wait_busy", bus.req_ready, 1'b0);
        rst = 1'b1;
        #1;
        check_reset("midreset");
        rsp_q.delete();
        mem_q.delete();
        exp_done--;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd20, 1'b1,
            mk_mem(32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h1357_9BDF, 0, 1'b0, 1'b1),
            mk_rsp(32'h1357_9BDF, 5'd20, 1'b1, 2'd0, 3, 0));

        repeat (5) @(negedge clk);
        check("rsp_count", rsp_done, exp_done);
        check("mem_queue_empty", mem_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/npc_lsu.md
Name: npc_lsu

Overview:
- Multi-cycle load/store unit for the NPC core. It replaces the single-cycle inline memory access path.
- Accepts one memory op per transaction from the EXU side over a valid/ready handshake.
- Drives an aligned, handshaked memory port with byte mask, then returns extracted, sign- or zero-extended load data plus the rd tag to the WBU.
- Parametrised in data width; adds misalignment detection and back-pressure.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 255, memory response watchdog limit (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: [1:0] size (0=B,1=H,2=W,3=D), [2] unsigned load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_rd  in  5  destination register tag.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  address aligned to XLEN/8 bytes.
- mem_wen  out  1  write enable.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wmask  out  XLEN/8  byte strobes.
- mem_rvalid  in  1  memory response valid (loads and stores).
- mem_rdata  in  XLEN  aligned read data.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  WBU accepts result.
- rsp_data  out  XLEN  extended load data; 0 for stores.
- rsp_rd  out  5  captured rd tag.
- rsp_wen  out  1  1 when a register write is required (load without error).
- rsp_err  out  2  0 ok, 1 misaligned, 2 timeout.

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset: state=IDLE; req_ready=1; mem_valid=0; rsp_valid=0; rsp_data=0; rsp_rd=0; rsp_wen=0; rsp_err=0; mem_wmask=0.
- IDLE:
  - req_ready=1. On req_valid&req_ready, capture wen, funct3, addr, wdata, rd.
  - Misaligned (addr mod size bytes != 0), or size=D with XLEN=32: go to RESP with err=1, no memory access.
  - Otherwise go to REQ.
- REQ:
  - mem_valid=1; outputs held stable until mem_ready.
  - mem_addr = addr with low log2(XLEN/8) bits cleared.
  - Lane offset = low bits. wmask = ((1<<bytes)-1) << offset, zero for loads.
  - wdata shifted left by 8*offset.
  - On mem_ready go to WAIT; mem_valid drops the next cycle.
- WAIT:
  - On mem_rvalid, shift mem_rdata right by 8*offset and truncate to size.
  - Extend: sign extension when funct3[2]=0, zero extension otherwise.
  - Register the result into rsp_data and go to RESP.
  - mem_rvalid arriving in the same cycle as mem_ready (REQ) is also accepted: go directly to RESP.
- RESP:
  - rsp_valid=1; outputs held stable until rsp_ready, then go to IDLE.
  - req_ready=0 in every state other than IDLE; no pipelining, at most one outstanding op.
- Latency: zero-wait memory gives request accept to rsp_valid in 3 cycles (IDLE→REQ→WAIT→RESP).
- mem_rvalid is ignored outside REQ/WAIT.
- rd=0 loads: rsp_wen=1 regardless; the register file discards the write.
- Reset mid-transaction: abort immediately to IDLE; any memory response already in flight is dropped.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - 8-bit-min counter cleared on entering REQ; increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES without completion: go to RESP with err=2, rsp_wen=0, rsp_data=0, mem_valid deasserted.
  - A late mem_rvalid is ignored.
- Undefined: no counter; the LSU waits indefinitely; err=2 is never produced.

Test Plan:
- Aligned lw: addr=0x80000004, mem_rdata=0xDEADBEEF, zero-wait memory → mem_addr=0x80000004, wmask=0, rsp_data=0xDEADBEEF, rsp_wen=1, rsp_valid 3 cycles after accept.
- Load byte extension: lb then lbu at addr=0x80000003, mem_rdata=0x80112233 → lb gives rsp_data=0xFFFFFF80; lbu gives 0x00000080.
- sb/sh lanes: sb addr=0x80000002 wdata=0x000000AB → mem_wdata=0x00AB0000, wmask=0x4. sh addr=0x80000002 wdata=0x1234 → wdata=0x12340000, wmask=0xC.
- Misaligned lw at 0x80000002 → mem_valid never asserts; rsp_err=1, rsp_wen=0 on the cycle after accept.
- Back-pressure: mem_ready low 5 cycles and rsp_ready low 3 cycles → mem_* and rsp_* stay stable throughout, req_ready=0, single response delivered.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_rvalid never asserted → rsp_err=2 after 16 cycles; a reset asserted mid-WAIT returns to IDLE with all outputs at reset values.
